// File: rtl/adc_frame_pkg.sv
// Shared types and helpers for the ADC sample framer: frame FSM states,
// sample packing width and the per-byte frame formatting functions.
package adc_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         SAMPLE_W      = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_HI,
    S_LO,
    S_CHK
  } frame_state_t;

  // Sample layout is {ch[2:0], data[11:0]}.
  function automatic logic [7:0] hi_byte(input logic [SAMPLE_W-1:0] s);
    return {1'b0, s[14:12], s[11:8]};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [SAMPLE_W-1:0] s);
    return s[7:0];
  endfunction

  function automatic logic [7:0] chk_byte(input logic [SAMPLE_W-1:0] s);
    return hi_byte(s) ^ lo_byte(s);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port: rdata shows the popped
// entry the cycle after pop. A push while full is accepted only if a pop
// frees a slot in the same cycle.
module sync_fifo
  import adc_frame_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage and read register carry data only; when full with a coincident
  // push and pop, wptr == rptr and the read returns the old entry.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
    if (do_pop)  rdata     <= mem[rptr];
  end

endmodule

// File: rtl/adc_sample_framer.sv
// Buffers LTC2308 conversions and streams each one as a 4-byte frame
// (SYNC, HI, LO, CHK) over a valid/ready byte interface towards the UART TX.
module adc_sample_framer
  import adc_frame_pkg::*;
#(
  parameter int         FIFO_AW   = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               adc_ready,
  input  logic [11:0]        adc_data,
  input  logic [2:0]         adc_ch,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [CNT_W-1:0]   overflow_count,
  output logic               busy
);

  logic                rdy_q;
  logic                push;
  logic                pop;
  logic                drop;
  logic                accept;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] sample_in;
  logic [SAMPLE_W-1:0] frame_q;
  frame_state_t        state;
  frame_state_t        state_nxt;
  logic [7:0]          tx_data_nxt;
  logic                tx_valid_nxt;

  assign sample_in = {adc_ch, adc_data};
  assign push      = enable & adc_ready & ~rdy_q;
  assign drop      = push & fifo_full & ~pop;
  assign accept    = tx_valid & tx_ready;

  always_ff @(posedge clock) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= adc_ready;
  end

  // The FIFO read register doubles as the frame register: it only changes
  // on pop, and pops happen only when a new frame starts.
  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (sample_in),
    .rdata (frame_q),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_count <= '0;
    end else if (drop && !(&overflow_count)) begin
      overflow_count <= overflow_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          state_nxt    = S_SYNC;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = SYNC_BYTE;
        end
      end
      S_SYNC: begin
        if (accept) begin
          state_nxt   = S_HI;
          tx_data_nxt = hi_byte(frame_q);
        end
      end
      S_HI: begin
        if (accept) begin
          state_nxt   = S_LO;
          tx_data_nxt = lo_byte(frame_q);
        end
      end
      S_LO: begin
        if (accept) begin
          state_nxt   = S_CHK;
          tx_data_nxt = chk_byte(frame_q);
        end
      end
      S_CHK: begin
        if (accept) begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            state_nxt   = S_SYNC;
            tx_data_nxt = SYNC_BYTE;
          end else begin
            state_nxt    = S_IDLE;
            tx_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        tx_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
    end
  end

  assign busy = (state != S_IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_adc_sample_framer.sv
// Bench for adc_sample_framer: a transaction-level model of captured samples
// and expected frame bytes, checked every cycle, plus directed literal checks.
module tb_adc_sample_framer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        adc_ready = 1'b0;
  logic [11:0] adc_data = '0;
  logic [2:0]  adc_ch = '0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  adc_sample_framer dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .adc_ready      (adc_ready),
    .adc_data       (adc_data),
    .adc_ch         (adc_ch),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Model state: samples waiting in the buffer, whether a frame is on the
  // wire, and the byte stream every accepted sample still owes.
  logic [7:0] exp_q[$];
  logic [7:0] acc_log[$];
  int         stored = 0;
  bit         in_flight = 0;
  int         frame_pos = 0;
  int         ovf = 0;
  bit         rdy_prev = 0;
  bit         model_on = 0;
  bit         after_reset = 0;
  logic       smp_valid;
  logic [7:0] smp_data;
  bit         push_ev, acc, done, pop_ev, full_pre;
  logic [7:0] hb, lb;

  initial forever begin
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      stored = 0; in_flight = 0; frame_pos = 0; ovf = 0;
      rdy_prev = 0; model_on = 1; after_reset = 1;
    end else if (model_on) begin
      after_reset = 0;
      push_ev  = enable && adc_ready && !rdy_prev;
      acc      = smp_valid && tx_ready;
      done     = 0;
      full_pre = (stored == 16);
      if (acc) begin
        acc_log.push_back(smp_data);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte: got %0h, required no byte", smp_data);
        end else begin
          check("stream_byte", smp_data, exp_q.pop_front());
        end
        frame_pos++;
        if (frame_pos == 4) begin frame_pos = 0; done = 1; end
      end
      pop_ev = (stored > 0) && (!in_flight || done);
      if (pop_ev) begin stored--; in_flight = 1; end
      else if (done) in_flight = 0;
      if (push_ev) begin
        if (full_pre && !pop_ev) begin
          if (ovf < 65535) ovf++;
        end else begin
          stored++;
          hb = {1'b0, adc_ch, adc_data[11:8]};
          lb = adc_data[7:0];
          exp_q.push_back(8'hA5);
          exp_q.push_back(hb);
          exp_q.push_back(lb);
          exp_q.push_back(hb ^ lb);
        end
      end
      rdy_prev = adc_ready;
    end
  end

  initial forever begin
    @(negedge clock);
    smp_valid = tx_valid;
    smp_data  = tx_data;
    if (model_on) begin
      check("m_tx_valid", tx_valid, in_flight);
      check("m_fifo_level", fifo_level, stored);
      check("m_overflow", overflow_count, ovf);
      check("m_busy", busy, (in_flight || stored != 0));
      if (in_flight && exp_q.size() > 0) check("m_tx_data", tx_data, exp_q[0]);
      if (after_reset) check("m_reset_tx_data", tx_data, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_sample(input logic [2:0] ch, input logic [11:0] d);
    adc_ch = ch; adc_data = d; adc_ready = 1'b1;
    @(negedge clock);
    adc_ready = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clock);
      n++;
    end
    check(name, busy, 0);
  endtask

  int base;
  int cnt;

  initial begin
    tick(3);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow_count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0; enable = 1'b1; tx_ready = 1'b1;
    tick(2);

    // 1: latency and byte order
    base = acc_log.size();
    send_sample(3'd0, 12'h801);
    check("t1_valid_n1", tx_valid, 0);
    tick(1);
    check("t1_valid_n2", tx_valid, 1);
    check("t1_sync", tx_data, 8'hA5);
    tick(1); check("t1_hi", tx_data, 8'h08);
    tick(1); check("t1_lo", tx_data, 8'h01);
    tick(1); check("t1_chk", tx_data, 8'h09);
    tick(1);
    check("t1_valid_end", tx_valid, 0);
    check("t1_busy_end", busy, 0);
    check("t1_nbytes", acc_log.size() - base, 4);

    // 2: channel 7 frame, busy drop right after CHK accept
    base = acc_log.size();
    send_sample(3'd7, 12'h911);
    tick(4);
    check("t2_chk_shown", tx_data, 8'h68);
    check("t2_busy_chk", busy, 1);
    tick(1);
    check("t2_busy_after", busy, 0);
    check("t2_b0", acc_log[base], 8'hA5);
    check("t2_b1", acc_log[base+1], 8'h79);
    check("t2_b2", acc_log[base+2], 8'h11);
    check("t2_b3", acc_log[base+3], 8'h68);

    // 3: back-pressure on HI
    tx_ready = 1'b0;
    send_sample(3'd0, 12'h801);
    tick(1);
    check("t3_sync", tx_data, 8'hA5);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_data", tx_data, 8'h08);
      check("t3_hold_valid", tx_valid, 1);
      tick(1);
    end
    tx_ready = 1'b1;
    tick(1);
    check("t3_lo_after", tx_data, 8'h01);
    wait_idle(20, "t3_idle");

    // 4: overflow; first sample sits in the stalled frame, 16 buffered, 4 dropped
    tx_ready = 1'b0;
    for (int i = 0; i < 21; i++) begin
      adc_ch = 3'(i % 8); adc_data = 12'(i * 193 + 5); adc_ready = 1'b1;
      tick(20);
      adc_ready = 1'b0;
      tick(60);
    end
    check("t4_level", fifo_level, 16);
    check("t4_overflow", overflow_count, 4);
    check("t4_stall_sync", tx_data, 8'hA5);
    base = acc_log.size();
    tx_ready = 1'b1;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 200) begin
      tick(1);
      cnt++;
    end
    check("t4_drain_cycles", cnt, 68);
    check("t4_drain_bytes", acc_log.size() - base, 68);
    check("t4_last_hi", acc_log[base+65], {1'b0, 3'd0, 4'(((16 * 193 + 5) >> 8) & 15)});

    // 5: held level gives one frame; edge while disabled gives none
    base = acc_log.size();
    adc_ch = 3'd1; adc_data = 12'h123; adc_ready = 1'b1;
    tick(50);
    adc_ready = 1'b0;
    wait_idle(20, "t5_idle");
    check("t5_one_frame", acc_log.size() - base, 4);
    base = acc_log.size();
    enable = 1'b0; adc_ready = 1'b1;
    tick(5);
    enable = 1'b1;
    tick(45);
    adc_ready = 1'b0;
    tick(10);
    check("t5_no_frame", acc_log.size() - base, 0);
    check("t5_busy", busy, 0);

    // 6: reset during LO
    check("t6_ovf_before", overflow_count, 4);
    send_sample(3'd2, 12'h345);
    tick(3);
    check("t6_lo_shown", tx_data, 8'h45);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_valid", tx_valid, 0);
    check("t6_level", fifo_level, 0);
    check("t6_overflow", overflow_count, 0);
    tick(2);
    base = acc_log.size();
    send_sample(3'd5, 12'hABC);
    wait_idle(20, "t6_idle");
    check("t6_nbytes", acc_log.size() - base, 4);
    check("t6_b0", acc_log[base], 8'hA5);
    check("t6_b1", acc_log[base+1], 8'h5A);
    check("t6_b2", acc_log[base+2], 8'hBC);
    check("t6_b3", acc_log[base+3], 8'hE6);
    check("end_exp_empty", exp_q.size(), 0);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
